// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM state encoding,
// err_code values, common keyboard command bytes and the frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RELEASE,
    SHIFT,
    WAIT_IDLE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NO_CLK  = 2'b01;
  localparam logic [1:0] ERR_BIT_TMO = 2'b10;
  localparam logic [1:0] ERR_NACK    = 2'b11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_ACK     = 8'hFA;

  // {stop, odd parity, data}; shifted out LSB first.
  function automatic logic [9:0] make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Conditions one asynchronous PS/2 pad input.
// Ports:
//   clk, clrn : system clock, async active-low reset
//   pad       : raw pad level (asynchronous)
//   level     : filtered line level (resets to 1, the idle bus level)
//   fall      : one-cycle pulse on each 1->0 change of level
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic clrn,
  input  logic pad,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // level only follows s2 once s2 has disagreed with it for FILTER_CYCLES
  // consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      fall  <= 1'b0;
      cnt   <= '0;
    end else begin
      s1   <= pad;
      s2   <= s1;
      fall <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
        level <= s2;
        fall  <= level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Takes a command byte over valid/ready,
// performs the clock-inhibit request-to-send, shifts the frame out on
// device-generated clocks and checks the device ACK.
// Ports:
//   clk, clrn              : system clock, async active-low reset
//   tx_data/tx_valid/tx_ready : command handshake (ready only in IDLE)
//   done                   : pulse after ACKed frame and idle bus
//   err, err_code          : abort pulse and cause (held until next accept)
//   busy                   : transmitter owns the bus
//   ps2_clk_in/ps2_data_in : asynchronous pad inputs
//   ps2_clk_oe/ps2_data_oe : open-drain pull-low enables
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned INHIBIT_CYCLES = 12_000,
  parameter int unsigned FIRST_TIMEOUT  = 2_000_000,
  parameter int unsigned BIT_TIMEOUT    = 200_000,
  parameter int unsigned FILTER_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // Inhibit is never allowed below 100 us whatever INHIBIT_CYCLES says.
  localparam int unsigned MIN_INHIBIT = CLK_HZ / 10_000;
  localparam int unsigned INH_EFF     = (INHIBIT_CYCLES > MIN_INHIBIT) ? INHIBIT_CYCLES : MIN_INHIBIT;
  localparam int unsigned TMAX        = (INH_EFF > FIRST_TIMEOUT) ? INH_EFF : FIRST_TIMEOUT;
  localparam int unsigned TW          = $clog2(TMAX + 1);

  logic          clk_f;
  logic          clk_fall;
  logic          data_f;
  logic          data_fall_unused;

  state_t        state;
  logic [9:0]    sr;
  logic [3:0]    k;
  logic [3:0]    k_next;
  logic [TW-1:0] timer;

  ps2_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_sync (
    .clk   (clk),
    .clrn  (clrn),
    .pad   (ps2_clk_in),
    .level (clk_f),
    .fall  (clk_fall)
  );

  ps2_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_sync (
    .clk   (clk),
    .clrn  (clrn),
    .pad   (ps2_data_in),
    .level (data_f),
    .fall  (data_fall_unused)
  );

  always_comb begin
    k_next = (k == 4'd11) ? k : k + 4'd1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      sr          <= '0;
      k           <= '0;
      timer       <= '0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_valid && tx_ready) begin
            sr         <= make_frame(tx_data);
            err_code   <= ERR_NONE;
            k          <= '0;
            timer      <= TW'(INH_EFF - 1);
            ps2_clk_oe <= 1'b1;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= INHIBIT;
          end else begin
            // Lags the done/err pulse by one cycle so ready follows it.
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end

        INHIBIT: begin
          if (timer == '0) begin
            ps2_clk_oe <= 1'b0;
            state      <= RELEASE;
          end else begin
            // Start bit asserted during the final inhibit cycle.
            if (timer == TW'(1)) begin
              ps2_data_oe <= 1'b1;
            end
            timer <= timer - 1'b1;
          end
        end

        RELEASE: begin
          timer <= TW'(FIRST_TIMEOUT);
          state <= SHIFT;
        end

        SHIFT: begin
          if (clk_fall) begin
            k     <= k_next;
            timer <= TW'(BIT_TIMEOUT);
            if (k_next <= 4'd9) begin
              ps2_data_oe <= ~sr[k_next - 4'd1];
            end else if (k_next == 4'd10) begin
              ps2_data_oe <= 1'b0;
            end else if (!data_f) begin
              state <= WAIT_IDLE;
            end else begin
              err_code    <= ERR_NACK;
              ps2_data_oe <= 1'b0;
              state       <= ERR;
            end
          end else if (timer == '0) begin
            err_code    <= (k == 4'd0) ? ERR_NO_CLK : ERR_BIT_TMO;
            ps2_data_oe <= 1'b0;
            state       <= ERR;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        WAIT_IDLE: begin
          if (clk_f && data_f) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (timer == '0) begin
            err_code <= ERR_BIT_TMO;
            state    <= ERR;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        ERR: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          err         <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned CLKHZ = 400_000;
  localparam int unsigned INH   = 40;
  localparam int unsigned FT    = 3000;
  localparam int unsigned BT    = 600;
  localparam int unsigned FILT  = 8;
  localparam int unsigned HALF  = 60;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       busy;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  assign ps2_clk_in  = !(ps2_clk_oe || dev_clk_low);
  assign ps2_data_in = !(ps2_data_oe || dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ         (CLKHZ),
    .INHIBIT_CYCLES (INH),
    .FIRST_TIMEOUT  (FT),
    .BIT_TIMEOUT    (BT),
    .FILTER_CYCLES  (FILT)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .busy        (busy),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    bit         chk_frame;
    logic [9:0] frame;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_m;
  logic [9:0]  cap_frame = '0;
  int          checks = 0;
  int          errors = 0;
  int          n_results = 0;
  int unsigned cyc = 0;
  int unsigned t_result = 0;
  int unsigned t_lastfall = 0;
  int unsigned t_release = 0;
  int unsigned inh_cnt = 0;
  int unsigned ov_cnt = 0;
  int unsigned inh_len = 0;
  int unsigned ov_len = 0;
  logic        clk_oe_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_win(input string name, input int unsigned act, input int unsigned lo, input int unsigned hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=bound expired required=event", name);
  endtask

  // Length of each clock pull and its overlap with the data pull.
  always @(negedge clk) begin
    clk_oe_q <= ps2_clk_oe;
    if (ps2_clk_oe && !clk_oe_q) begin
      inh_cnt <= 1;
      ov_cnt  <= 32'(ps2_data_oe);
    end else if (ps2_clk_oe) begin
      inh_cnt <= inh_cnt + 1;
      ov_cnt  <= ov_cnt + 32'(ps2_data_oe);
    end
    if (!ps2_clk_oe && clk_oe_q) begin
      inh_len   <= inh_cnt;
      ov_len    <= ov_cnt;
      t_release <= cyc;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (done || err) begin
      n_results++;
      t_result = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=done%0b/err%0b required=none", done, err);
      end else begin
        e_m = sb.pop_front();
        chk("done_err_pulse", {30'd0, done, err}, e_m.is_err ? 32'd1 : 32'd2);
        chk("err_code", err_code, e_m.code);
        if (e_m.chk_frame) chk("frame_bits", cap_frame, e_m.frame);
        if (err) chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int unsigned i;
    i = 0;
    @(negedge clk);
    while (!tx_ready && i < 5000) begin
      @(negedge clk);
      i++;
    end
    if (!tx_ready) begin
      fail("ready_timeout");
      return;
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hs_clk_oe", ps2_clk_oe, 1);
    chk("hs_ready_low", tx_ready, 0);
    tx_valid = 1'b0;
  endtask

  // Device: waits for request-to-send, then produces n_edges clocks.
  task automatic dev_frame(input int n_edges, input bit nack, input bit glitch);
    int unsigned w;
    w = 0;
    while (!(ps2_clk_in && !ps2_data_in) && w < 2000) begin
      @(posedge clk);
      w++;
    end
    if (!(ps2_clk_in && !ps2_data_in)) begin
      fail("rts_timeout");
      return;
    end
    repeat (20) @(posedge clk);
    for (int i = 1; i <= n_edges; i++) begin
      if (i == 11 && !nack) begin
        dev_data_low = 1'b1;
        repeat (5) @(posedge clk);
      end
      dev_clk_low = 1'b1;
      t_lastfall  = cyc;
      repeat (HALF) @(posedge clk);
      dev_clk_low = 1'b0;
      if (i <= 10) cap_frame[i-1] = ps2_data_in;
      if (glitch && i >= 2 && i <= 9) begin
        repeat (HALF / 2) @(posedge clk);
        dev_clk_low = 1'b1;
        repeat (3) @(posedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF - HALF / 2 - 3) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
      if (i == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_result(input int r0);
    int unsigned i;
    i = 0;
    while (n_results == r0 && i < 10000) begin
      @(negedge clk);
      i++;
    end
    if (n_results == r0) fail("result_timeout");
  endtask

  initial begin
    int r0;
    clrn     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED, ACK: bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
    r0 = n_results;
    sb.push_back('{is_err: 1'b0, code: ERR_NONE, chk_frame: 1'b1, frame: 10'h3ED});
    send(8'hED);
    dev_frame(11, 1'b0, 1'b0);
    wait_result(r0);
    chk("inhibit_len", inh_len, INH);
    chk("start_overlap", ov_len, 1);

    // 0x00, NACK: parity 1.
    r0 = n_results;
    sb.push_back('{is_err: 1'b1, code: ERR_NACK, chk_frame: 1'b1, frame: 10'h300});
    send(8'h00);
    dev_frame(11, 1'b1, 1'b0);
    wait_result(r0);
    repeat (5) @(negedge clk);
    chk("err_code_held", err_code, 3);
    chk("nack_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // 0xFF, silent device.
    r0 = n_results;
    sb.push_back('{is_err: 1'b1, code: ERR_NO_CLK, chk_frame: 1'b0, frame: 10'h000});
    send(8'hFF);
    dev_frame(0, 1'b0, 1'b0);
    wait_result(r0);
    chk_win("first_timeout", t_result - t_release, FT, FT + 4);

    // Device stops after 4 clocks.
    r0 = n_results;
    sb.push_back('{is_err: 1'b1, code: ERR_BIT_TMO, chk_frame: 1'b0, frame: 10'h000});
    send(8'hF4);
    dev_frame(4, 1'b0, 1'b0);
    wait_result(r0);
    chk_win("bit_timeout", t_result - t_lastfall, BT + FILT, BT + FILT + 8);

    // Reset at k=5 (bit 4 of 0xED is 0, so data is pulled).
    send(8'hED);
    dev_frame(5, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_data_oe", ps2_data_oe, 1);
    @(posedge clk);
    #3 clrn = 1'b0;
    #1;
    chk("arst_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("arst_tx_ready", tx_ready, 1);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    clrn = 1'b1;

    // 0xF4 after reset: parity 0.
    r0 = n_results;
    sb.push_back('{is_err: 1'b0, code: ERR_NONE, chk_frame: 1'b1, frame: 10'h2F4});
    send(8'hF4);
    dev_frame(11, 1'b0, 1'b0);
    wait_result(r0);

    // 0xED with 3-cycle clock glitches.
    r0 = n_results;
    sb.push_back('{is_err: 1'b0, code: ERR_NONE, chk_frame: 1'b1, frame: 10'h3ED});
    send(8'hED);
    dev_frame(11, 1'b0, 1'b1);
    wait_result(r0);

    repeat (10) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the sending side of the keyboard link whose receive side is decoded by `KeyboardControl`. It accepts a command byte over a valid/ready handshake and drives an open-drain clock/data request-to-send sequence. It then shifts out the frame on device-generated clocks and checks the device ACK. Typical commands are 0xED (set LEDs, e.g. the led toggle on space), 0xFF (reset) and 0xF4 (enable). It sits beside `KeyboardControl` in the top-level shell. Its `busy` output gates the receiver during host frames.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `INHIBIT_CYCLES`, 12_000: clock-low inhibit time, 120 µs at 100 MHz; must be ≥ 100 µs.
- `FIRST_TIMEOUT`, 2_000_000: maximum wait from clock release to the first device falling edge (20 ms).
- `BIT_TIMEOUT`, 200_000: maximum gap between consecutive device falling edges (2 ms).
- `FILTER_CYCLES`, 8: number of cycles a synchronized line must be stable before its filtered value changes.
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `clrn`, input, 1: asynchronous active-low reset.
- `tx_data`, input, 8: command byte; sampled when `tx_valid & tx_ready`.
- `tx_valid`, input, 1: a request is pending.
- `tx_ready`, output, 1: high only in IDLE.
- `done`, output, 1: one-cycle pulse after a frame is ACKed and the bus is back to idle.
- `err`, output, 1: one-cycle pulse when a frame aborts.
- `err_code`, output, 2: 00 none, 01 no first clock, 10 bit timeout, 11 NACK. Holds its value until the next frame is accepted.
- `busy`, output, 1: high in every state except IDLE.
- `ps2_clk_in`, input, 1: PS/2 clock pad input (asynchronous).
- `ps2_data_in`, input, 1: PS/2 data pad input (asynchronous).
- `ps2_clk_oe`, output, 1: 1 pulls the clock pad low; 0 releases it.
- `ps2_data_oe`, output, 1: 1 pulls the data pad low; 0 releases it.

## Operation
- Input conditioning: each pad input passes through a 2-flop synchronizer and then the stability filter. A one-cycle `fall` pulse is generated on each 1→0 transition of the filtered clock.
- Frame contents: sr = {stop=1, parity=~^tx_data, tx_data}, transmitted LSB first.
- IDLE: `tx_ready`=1 and both line drivers released. On handshake, latch the frame into sr, clear `err_code` and the edge counter k, and go to INHIBIT.
- INHIBIT: `ps2_clk_oe`=1 for INHIBIT_CYCLES. In the last cycle also set `ps2_data_oe`=1 (start bit), then go to RELEASE.
- RELEASE: `ps2_clk_oe`=0 while `ps2_data_oe` stays 1. Load the timer with FIRST_TIMEOUT and go to SHIFT.
- SHIFT, on each `fall`, increment k and reload the timer with BIT_TIMEOUT:
  - k=1..9: `ps2_data_oe` = ~sr[k-1]; this covers data bits 0–7 and then parity.
  - k=10: `ps2_data_oe`=0, releasing data for the stop bit.
  - k=11: sample filtered data. 0 means ACK: go to WAIT_IDLE. 1 means NACK: go to ERR with code 11.
- Timer expiry in SHIFT goes to ERR: code 01 if k=0, otherwise code 10.
- WAIT_IDLE: wait until filtered clock and data are both 1, then pulse `done` and return to IDLE. If this takes longer than BIT_TIMEOUT, go to ERR with code 10.
- ERR: release both lines, pulse `err`, return to IDLE.
- Behaviour in any state other than IDLE: `tx_valid` is ignored; the requester must hold it.
- Device-initiated traffic: not arbitrated. Issuing a request while the keyboard is mid-frame corrupts that frame, which is accepted behaviour per the PS/2 protocol (host inhibit wins).

## Timing
- Reset state, applied asynchronously: IDLE, with `tx_ready`=1, `busy`=0, `done`=0, `err`=0, `err_code`=00, `ps2_clk_oe`=0, `ps2_data_oe`=0.
- Reset asserted mid-frame releases both lines immediately, with no clock edge needed.
- Handshake to `ps2_clk_oe`=1: 1 cycle.
- `ps2_clk_oe` stays high for exactly INHIBIT_CYCLES cycles.
- `ps2_data_oe` rises in the last inhibit cycle and overlaps the clock pull for 1 cycle.
- Pad edge to `fall` pulse: 2 sync cycles + FILTER_CYCLES + 1.
- `fall` to data update: 1 cycle. The whole path is well inside the ≥ 5 µs device clock-low phase.
- `done` and `err` are registered and mutually exclusive. `tx_ready` rises in the cycle after the pulse.
- Timer widths: ceil(log2(max(INHIBIT_CYCLES, FIRST_TIMEOUT) + 1)) bits. k is a 4-bit counter and saturates at 11.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum (IDLE, INHIBIT, RELEASE, SHIFT, WAIT_IDLE, ERR);
  - the `err_code` constants;
  - command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, CMD_ACK=8'hFA.
- Sub-module `ps2_line_sync`, instantiated once for clock and once for data. It contains the 2-flop synchronizer, the FILTER_CYCLES stability filter, the filtered level output and the `fall` pulse. Its reset value is 1.

## Test plan
All scenarios use a bench device model that drives a 12 kHz clock after seeing the host request.
- Send 0xED with the model ACKing. Required: frame bits 1,0,1,1,0,1,1,1 LSB-first, parity 1, stop released, `done` pulses once, `err_code`=00, `ps2_clk_oe` high for exactly 12_000 cycles.
- Send 0x00 with the model NACKing (data high on clock 11). Required: parity bit 1, `err` pulse, `err_code`=11, both lines released.
- Send 0xFF with the model silent. Required: `err` pulse with code 01 exactly 2_000_000 cycles after RELEASE.
- Model stops clocking after 4 edges. Required: `err` with code 10 at 200_000 cycles after the last edge.
- Assert `clrn` low at k=5. Required: `ps2_clk_oe`=`ps2_data_oe`=0 within the same cycle, `tx_ready`=1, and a following 0xF4 send completes with `done`.
- Inject 3-cycle glitches on `ps2_clk_in` during SHIFT. Required: no change in k, and the frame still ACKs.
